uart_ram_cmd: RTL
=================

// Module: uart_ram_cmd
// PURPOSE
//  Byte-level command front-end feeding the dual-port block RAM (1024x16, registered read).
//  Consumes bytes from the UART receiver, decodes write/read commands, drives the RAM
//  write and read ports, and returns read data or acknowledges to the UART transmitter.
//  Sits between the UART RX/TX byte interfaces and the RAM, on the same clock as the RAM.
// PARAMETERS
//  ADDR_W   10     RAM address width; address = low ADDR_W bits of {addr_hi,addr_lo}
//  TIMEOUT  50000  idle cycles allowed between argument bytes before abort (>=2)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       asynchronous, active-high reset
//  rx_data     in   8       received byte
//  rx_valid    in   1       one-cycle strobe, rx_data valid; no backpressure
//  tx_data     out  8       byte to transmit
//  tx_valid    out  1       tx_data valid; held until accepted
//  tx_ready    in   1       transmitter accepts when tx_valid & tx_ready at posedge
//  ram_wren    out  1       RAM write enable, one-cycle pulse
//  ram_wraddr  out  ADDR_W  RAM write address
//  ram_di      out  16      RAM write data
//  ram_rden    out  1       RAM read enable, one-cycle pulse
//  ram_rdaddr  out  ADDR_W  RAM read address
//  ram_do      in   16      RAM read data, valid the cycle after ram_rden
//  err         out  1       one-cycle pulse: timeout abort or byte dropped while busy
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; arg counter, timeout counter, addr/data regs cleared.
//  Protocol (big-endian): 0x57 'W' ah al dh dl -> write, reply 0x4B 'K';
//    0x52 'R' ah al -> read, reply dh then dl; any other cmd byte -> reply 0x3F '?'.
//  States: IDLE, ARGS, WRITE, RD_REQ, RD_WAIT, TX0, TX1.
//  IDLE: on rx_valid latch cmd; W/R -> ARGS (need 4/2 bytes); else load '?' -> TX1.
//  ARGS: each rx_valid shifts byte in; on last byte -> WRITE (W) or RD_REQ (R).
//  WRITE: single cycle; ram_wren=1, ram_wraddr/ram_di from latched args; load 'K' -> TX1.
//  RD_REQ: single cycle; ram_rden=1, ram_rdaddr=addr -> RD_WAIT.
//  RD_WAIT: capture ram_do into data reg (exactly 1 cycle after rden) -> TX0 with dh.
//  TX0: tx_valid=1, tx_data=data[15:8]; on tx_ready -> TX1 with data[7:0].
//  TX1: tx_valid=1; on tx_ready -> IDLE. tx_data stable while tx_valid & !tx_ready.
//  Latency: last arg byte strobe at cycle N -> ram_wren at N+1 / ram_rden at N+1,
//    tx_valid first asserted N+2 (write) or N+3 (read).
//  ram_wraddr/ram_rdaddr/ram_di are registered; hold last value outside pulses.
//  Timeout: counter clears on every rx_valid and on entering ARGS; counts only in ARGS;
//    reaching TIMEOUT -> err pulse, discard partial command, -> IDLE.
//  rx_valid in WRITE, RD_REQ, RD_WAIT, TX0, TX1: byte dropped, err pulse, state unaffected.
//  rx_valid in same cycle as timeout expiry: byte wins, counter clears, no err.
//  Address bytes wider than ADDR_W: upper bits ignored (wrap modulo 2^ADDR_W).
//  Never assert ram_wren and ram_rden in the same cycle.
//  rst mid-command or mid-TX: immediate abort, tx_valid drops, no RAM write issued.
// TESTING
//  1. rx 57 00 05 BE EF, tx_ready=1 -> one ram_wren, wraddr=0x005, di=0xBEEF; tx 0x4B.
//  2. After 1, rx 52 00 05 -> ram_rden with rdaddr=0x005; tx BE then EF.
//  3. rx 52 FC 03, tx_ready held 0 for 20 cycles -> addr=0x003; tx_valid stays 1,
//     tx_data=dh stable; release -> dh, dl in order.
//  4. rx 57 01, then silence TIMEOUT cycles -> err pulse, IDLE, no wren; next 52 01 00
//     decodes normally.
//  5. rx 0x41 -> tx 0x3F; rx byte during TX0 stall -> err pulse, reply unchanged.
//  6. assert rst after 57 00 05 BE -> all outputs 0; following dl byte treated as cmd ('?').

Source files
------------

// File: rtl/uart_ram_cmd.sv
// Byte command front-end between the UART byte interfaces and a 1024x16 registered-read RAM.
// Decodes 'W' ah al dh dl (write, reply 'K') and 'R' ah al (read, reply dh dl); anything else gets '?'.
//   state   | meaning
//   IDLE    | waiting for a command byte
//   ARGS    | collecting address/data bytes, timeout armed
//   WRITE   | one-cycle RAM write pulse
//   RD_REQ  | one-cycle RAM read pulse
//   RD_WAIT | RAM output valid, capture it
//   TX0     | offering the high reply byte
//   TX1     | offering the low (or only) reply byte
module uart_ram_cmd #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [15:0]       ram_di,
    output logic              ram_rden,
    output logic [ADDR_W-1:0] ram_rdaddr,
    input  logic [15:0]       ram_do,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, ARGS, WRITE, RD_REQ, RD_WAIT, TX0, TX1} state_t;

    localparam int         TW    = $clog2(TIMEOUT);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;

    state_t          state, state_nxt;
    logic            is_wr;
    logic [1:0]      arg_cnt;
    logic [23:0]     arg_sr;
    logic [15:0]     data;
    logic [TW-1:0]   tmo_cnt;
    logic            err_nxt;

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        ram_wren  = 1'b0;
        ram_rden  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R) state_nxt = ARGS;
                    else                                      state_nxt = TX1;
                end
            end
            ARGS: begin
                // a byte landing on the expiry cycle wins over the timeout
                if (rx_valid) begin
                    if (arg_cnt == 2'd0) state_nxt = is_wr ? WRITE : RD_REQ;
                end else if (tmo_cnt == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                ram_wren  = 1'b1;
                state_nxt = TX1;
            end
            RD_REQ: begin
                ram_rden  = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: state_nxt = TX0;
            TX0: begin
                tx_valid = 1'b1;
                tx_data  = data[15:8];
                if (tx_ready) state_nxt = TX1;
            end
            TX1: begin
                tx_valid = 1'b1;
                tx_data  = data[7:0];
                if (tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rx_valid && state != IDLE && state != ARGS) err_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            err        <= 1'b0;
            is_wr      <= 1'b0;
            arg_cnt    <= 2'd0;
            arg_sr     <= '0;
            data       <= '0;
            tmo_cnt    <= '0;
            ram_wraddr <= '0;
            ram_di     <= '0;
            ram_rdaddr <= '0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;

            if ((state == IDLE || state == ARGS) && rx_valid)
                tmo_cnt <= TW'(TIMEOUT - 1);
            else if (state == ARGS && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;

            if (state == IDLE && rx_valid) begin
                is_wr   <= (rx_data == CMD_W);
                arg_cnt <= (rx_data == CMD_W) ? 2'd3 : 2'd1;
                if (rx_data != CMD_W && rx_data != CMD_R) data <= {8'h00, RSP_Q};
            end

            if (state == ARGS && rx_valid) begin
                arg_sr  <= {arg_sr[15:0], rx_data};
                arg_cnt <= arg_cnt - 2'd1;
                if (arg_cnt == 2'd0) begin
                    if (is_wr) begin
                        ram_wraddr <= ADDR_W'(arg_sr[23:8]);
                        ram_di     <= {arg_sr[7:0], rx_data};
                    end else begin
                        ram_rdaddr <= ADDR_W'({arg_sr[7:0], rx_data});
                    end
                end
            end

            if (state == WRITE)   data <= {8'h00, RSP_K};
            if (state == RD_WAIT) data <= ram_do;
        end
    end

endmodule
